// File: rtl/carwash_pkg.sv
// Shared car wash types and default timing constants.
// Used by the timer unit and the wash controller for T1/T2 naming.
package carwash_pkg;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} tmr_state_t;

    localparam int TICK_DIV_DEF = 100;
    localparam int T1_LEN_DEF   = 8;
    localparam int T2_LEN_DEF   = 4;
    localparam int CNT_W_DEF    = 16;

    // Prescaler width, never narrower than one bit.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/carwash_timer.sv
// One elapsed-time timer: prescaler plus saturating tick counter, sticky done flag.
// Optional PAUSE input is built in when CARWASH_PAUSE_EN is defined.
module carwash_timer
    import carwash_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int LEN      = T1_LEN_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic CLR_N,
    input  logic clr,
`ifdef CARWASH_PAUSE_EN
    input  logic pause,
`endif
    output logic done
);

    localparam int               PW        = presc_width(TICK_DIV);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LEN_C     = CNT_W'(LEN);

    tmr_state_t       state, state_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hold;

`ifdef CARWASH_PAUSE_EN
    // Pause only freezes an active run; the IDLE->RUN edge always counts.
    assign hold = pause && (state == T_RUN);
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge CLR_N) begin
        if (!CLR_N) begin
            state <= T_IDLE;
            presc <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            presc <= presc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = T_IDLE;
            presc_nxt = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                T_IDLE, T_RUN: begin
                    if (!hold) begin
                        state_nxt = T_RUN;
                        if (presc == PRESC_MAX) begin
                            presc_nxt = '0;
                            cnt_nxt   = cnt + 1'b1;
                            if (cnt_nxt == LEN_C)
                                state_nxt = T_DONE;
                        end else begin
                            presc_nxt = presc + 1'b1;
                        end
                    end
                end
                T_DONE:  state_nxt = T_DONE;
                default: state_nxt = T_IDLE;
            endcase
        end
    end

    // Done decodes the state register, so it never follows clr combinationally.
    always_comb begin
        done = (state == T_DONE);
    end

endmodule

// File: rtl/carwash_timer_unit.sv
// Timer side of the car wash handshake: two independent timers (spray, rinse).
// Define CARWASH_PAUSE_EN to add the PAUSE input shared by both timers.
module carwash_timer_unit
    import carwash_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int T1_LEN   = T1_LEN_DEF,
    parameter int T2_LEN   = T2_LEN_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic CLR_N,
    input  logic CLRT1,
    input  logic CLRT2,
`ifdef CARWASH_PAUSE_EN
    input  logic PAUSE,
`endif
    output logic T1DONE,
    output logic T2DONE
);

    carwash_timer #(.TICK_DIV(TICK_DIV), .LEN(T1_LEN), .CNT_W(CNT_W)) u_t1 (
        .clk   (clk),
        .CLR_N (CLR_N),
        .clr   (CLRT1),
`ifdef CARWASH_PAUSE_EN
        .pause (PAUSE),
`endif
        .done  (T1DONE)
    );

    carwash_timer #(.TICK_DIV(TICK_DIV), .LEN(T2_LEN), .CNT_W(CNT_W)) u_t2 (
        .clk   (clk),
        .CLR_N (CLR_N),
        .clr   (CLRT2),
`ifdef CARWASH_PAUSE_EN
        .pause (PAUSE),
`endif
        .done  (T2DONE)
    );

endmodule
